// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_pkg
//  Purpose  : Shared definitions for the PC / fetch sequencer: FSM state
//             encoding and the Thumb-style PC arithmetic constants.
//  Revision : 1.0 - initial release
// ============================================================================
package arm_pkg;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // PC advance per 16-bit fetch
  localparam int unsigned C_PC_INC   = 2;
  // PC reads as branch address + 4 when the branch executes
  localparam int unsigned C_PIPE_OFS = 4;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target_calc
//  Purpose  : Combinational branch target: br_pc + 4 + (sext(offset) << 1),
//             wrapping modulo 2^ADDR_W, with bit 0 forced to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_target_calc
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF_W  = 11
) (
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [OFF_W-1:0]  br_offset_i,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_sum;

  // Sign-extend the halfword offset, scale to bytes, add to the pipelined PC
  always_comb begin
    w_off_ext = {{(ADDR_W-OFF_W){br_offset_i[OFF_W-1]}}, br_offset_i};
    w_sum     = br_pc_i + ADDR_W'(C_PIPE_OFS) + (w_off_ext << 1);
    // Halfword-aligned fetch: an odd br_pc must never produce an odd target
    target_o  = w_sum & ({ADDR_W{1'b1}} << 1);
  end

endmodule : branch_target_calc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program counter and instruction fetch sequencer. Resolves
//             branches from the condition check, redirects the PC, holds a
//             fixed-length flush after a taken branch and issues fetches.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import arm_pkg::*;
#(
  parameter int unsigned   ADDR_W       = 32,
  parameter int unsigned   OFF_W        = 11,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned   FLUSH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic              br_uncond_i,
  input  logic              br_ok_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [OFF_W-1:0]  br_offset_i,
  input  logic              imem_gnt_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              fetch_valid_o,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic              flush_o,
  output logic              taken_o
);

  localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              taken_q, taken_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] w_target;
  logic              w_take;
  logic              w_req;

  branch_target_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_btc (
    .br_pc_i     (br_pc_i),
    .br_offset_i (br_offset_i),
    .target_o    (w_target)
  );

  // Next-state, PC update and request generation
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = 1'b0;
    taken_d       = 1'b0;
    cnt_d         = cnt_q;
    w_req         = 1'b0;
    // br_valid gates first so br_ok is a don't-care when no branch is present
    w_take        = br_valid_i && (br_uncond_i || br_ok_i);

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        w_req = !stall_i;
        // A taken branch wins over both stall and a same-cycle grant
        if (w_take) begin
          pc_d    = w_target;
          taken_d = 1'b1;
          cnt_d   = C_FLUSH_LOAD;
          state_d = ST_FLUSH;
        end else if (w_req && imem_gnt_i) begin
          pc_d          = pc_q + ADDR_W'(C_PC_INC);
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers, asynchronously reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VEC;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      taken_q       <= 1'b0;
      cnt_q         <= 4'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      taken_q       <= taken_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign flush_o       = (state_q == ST_FLUSH);
  assign taken_o       = taken_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed, table-driven self-checking bench for pc_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_uncond;
  logic        br_ok;
  logic [31:0] br_pc;
  logic [10:0] br_offset;
  logic        imem_gnt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        taken;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .ADDR_W       (32),
    .OFF_W        (11),
    .RESET_VEC    (32'h0000_0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .stall_i       (stall),
    .br_valid_i    (br_valid),
    .br_uncond_i   (br_uncond),
    .br_ok_i       (br_ok),
    .br_pc_i       (br_pc),
    .br_offset_i   (br_offset),
    .imem_gnt_i    (imem_gnt),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .fetch_valid_o (fetch_valid),
    .fetch_pc_o    (fetch_pc),
    .flush_o       (flush),
    .taken_o       (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        bv;
    logic        bu;
    logic        bo;
    logic [31:0] bpc;
    logic [10:0] boff;
    logic        gnt;
    logic        req;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] fpc;
    logic        fl;
    logic        tk;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic bv, input logic bu, input logic bo,
                     input logic [31:0] bpc, input logic [10:0] boff, input logic gnt,
                     input logic req, input logic [31:0] addr, input logic fv,
                     input logic [31:0] fpc, input logic fl, input logic tk);
    vec_t v;
    v.st = st; v.bv = bv; v.bu = bu; v.bo = bo; v.bpc = bpc; v.boff = boff; v.gnt = gnt;
    v.req = req; v.addr = addr; v.fv = fv; v.fpc = fpc; v.fl = fl; v.tk = tk;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    stall     = v.st;
    br_valid  = v.bv;
    br_uncond = v.bu;
    br_ok     = v.bo;
    br_pc     = v.bpc;
    br_offset = v.boff;
    imem_gnt  = v.gnt;
  endtask

  initial begin
    // inputs: st bv bu bo bpc boff gnt | expected: req addr fv fpc flush taken
    // boot, then sequential fetches 0,2,4
    add(0,0,0,0,32'h0,11'h0,1,  0,32'h0,0,32'h0,0,0);           // c0 BOOT
    add(0,0,0,0,32'h0,11'h0,1,  1,32'h0,0,32'h0,0,0);           // c1
    add(0,0,0,0,32'h0,11'h0,1,  1,32'h2,1,32'h0,0,0);           // c2
    add(0,0,0,0,32'h0,11'h0,1,  1,32'h4,1,32'h2,0,0);           // c3
    // taken conditional: 0x100+4+0x20 = 0x124; same-cycle grant discarded
    add(0,1,0,1,32'h100,11'h010,1, 1,32'h6,1,32'h4,0,0);        // c4
    // second branch during flush must be ignored
    add(0,1,0,1,32'h200,11'h010,1, 0,32'h124,0,32'h4,1,1);      // c5
    add(0,0,0,0,32'h0,11'h0,1,  0,32'h124,0,32'h4,1,0);         // c6
    // not-taken branch: pc keeps incrementing
    add(0,1,0,0,32'h40,11'h0,1, 1,32'h124,0,32'h4,0,0);         // c7
    // stall with grant: nothing issued
    add(1,0,0,0,32'h0,11'h0,1,  0,32'h126,1,32'h124,0,0);       // c8
    // unconditional, offset -2 from 0x0 -> target 0x0, under stall
    add(1,1,1,0,32'h0,11'h7FE,1, 0,32'h126,0,32'h124,0,0);      // c9
    add(0,0,0,0,32'h0,11'h0,1,  0,32'h0,0,32'h124,1,1);         // c10
    add(0,0,0,0,32'h0,11'h0,1,  0,32'h0,0,32'h124,1,0);         // c11
    // branch to 0xFFFF_FFFE: 0xFFFF_FFF0 + 4 + 10
    add(0,1,1,0,32'hFFFF_FFF0,11'h005,1, 1,32'h0,0,32'h124,0,0); // c12
    add(0,0,0,0,32'h0,11'h0,1,  0,32'hFFFF_FFFE,0,32'h124,1,1); // c13
    add(0,0,0,0,32'h0,11'h0,1,  0,32'hFFFF_FFFE,0,32'h124,1,0); // c14
    // grant at 0xFFFF_FFFE wraps to 0
    add(0,0,0,0,32'h0,11'h0,1,  1,32'hFFFF_FFFE,0,32'h124,0,0); // c15
    add(0,0,0,0,32'h0,11'h0,0,  1,32'h0,1,32'hFFFF_FFFE,0,0);   // c16
    // odd branch pc: 0x301+4 = 0x305 -> bit 0 cleared -> 0x304
    add(0,1,1,0,32'h301,11'h0,0, 1,32'h0,0,32'hFFFF_FFFE,0,0);  // c17
    add(0,0,0,0,32'h0,11'h0,0,  0,32'h304,0,32'hFFFF_FFFE,1,1); // c18
    add(0,0,0,0,32'h0,11'h0,0,  0,32'h304,0,32'hFFFF_FFFE,1,0); // c19
    add(0,0,0,0,32'h0,11'h0,0,  1,32'h304,0,32'hFFFF_FFFE,0,0); // c20

    stall = 0; br_valid = 0; br_uncond = 0; br_ok = 0;
    br_pc = '0; br_offset = '0; imem_gnt = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // values while held in reset
    chk("rst_req",   {31'b0, imem_req},    32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_fv",    {31'b0, fetch_valid}, 32'h0);
    chk("rst_fpc",   fetch_pc,             32'h0);
    chk("rst_flush", {31'b0, flush},       32'h0);
    chk("rst_taken", {31'b0, taken},       32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("c%0d_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].req});
      chk($sformatf("c%0d_addr", i),  imem_addr,            vecs[i].addr);
      chk($sformatf("c%0d_fv", i),    {31'b0, fetch_valid}, {31'b0, vecs[i].fv});
      if (vecs[i].fv)
        chk($sformatf("c%0d_fpc", i), fetch_pc,             vecs[i].fpc);
      chk($sformatf("c%0d_flush", i), {31'b0, flush},       {31'b0, vecs[i].fl});
      chk($sformatf("c%0d_taken", i), {31'b0, taken},       {31'b0, vecs[i].tk});
      @(posedge clk);
      #1;
    end

    // Async reset during the second flush cycle
    stall = 0; br_valid = 1; br_uncond = 1; br_ok = 0;
    br_pc = 32'h10; br_offset = 11'h0; imem_gnt = 1'b1;
    #2;
    chk("ar_req_branch_cycle", {31'b0, imem_req}, 32'h1);
    @(posedge clk);
    #1;
    br_valid = 0;
    chk("ar_flush1",  {31'b0, flush}, 32'h1);
    chk("ar_taken1",  {31'b0, taken}, 32'h1);
    chk("ar_target",  imem_addr,      32'h14);
    @(posedge clk);
    #1;
    chk("ar_flush2",  {31'b0, flush}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_flush_async", {31'b0, flush},    32'h0);
    chk("ar_taken_async", {31'b0, taken},    32'h0);
    chk("ar_req_async",   {31'b0, imem_req}, 32'h0);
    chk("ar_pc_async",    imem_addr,         32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    chk("ar_boot_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    chk("ar_run_req",  {31'b0, imem_req}, 32'h1);
    chk("ar_run_addr", imem_addr,         32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
